// File: rtl/pmix_code_ctrl.sv
// Phase-mixer code controller: turns CDR up/down decisions into a {coarse, fine} mixer code,
// with wrap/clamp at the range ends and settling hold-off between code updates.
module pmix_code_ctrl #(
    parameter int unsigned NUM_PHASES     = 4,
    parameter int unsigned SEL_W          = $clog2(NUM_PHASES),
    parameter int unsigned FINE_W         = 8,
    parameter int unsigned STEP_W         = 4,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned XSETTLE_CYCLES = 4,
    parameter int unsigned SAT_MODE       = 0
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic                    En,
    input  logic                    Up,
    input  logic                    Dn,
    input  logic [STEP_W-1:0]       Step,
    input  logic                    Load,
    input  logic [SEL_W+FINE_W-1:0] Load_Code,
    output logic [SEL_W+FINE_W-1:0] Code,
    output logic [SEL_W-1:0]        P1_Sel,
    output logic [SEL_W-1:0]        P2_Sel,
    output logic                    Update,
    output logic                    Busy,
    output logic                    Slip_Up,
    output logic                    Slip_Dn,
    output logic                    Sat
);

    localparam int unsigned CodeW     = SEL_W + FINE_W;
    localparam int unsigned SettleMax = SETTLE_CYCLES + XSETTLE_CYCLES;
    localparam int unsigned CntW      = (SettleMax < 1) ? 1 : $clog2(SettleMax + 1);
    localparam bit          SatEn     = (SAT_MODE != 0);

    // NUM_PHASES is a power of 2, so the range is exactly 2^CodeW.
    localparam logic [CodeW:0]  RangeVal   = {1'b1, {CodeW{1'b0}}};
    localparam logic [CntW-1:0] SettleBase = CntW'(SETTLE_CYCLES);
    localparam logic [CntW-1:0] SettleX    = CntW'(XSETTLE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StSettle
    } state_e;

    state_e            state_q, state_d;
    logic [CodeW-1:0]  code_q, code_d;
    logic [CodeW-1:0]  pend_q, pend_d;
    logic              pslip_up_q, pslip_up_d;
    logic              pslip_dn_q, pslip_dn_d;
    logic              psat_q, psat_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              update_q, update_d;
    logic              slip_up_q, slip_up_d;
    logic              slip_dn_q, slip_dn_d;
    logic              sat_q, sat_d;

    logic [CodeW:0]    code_ext, step_ext, sum_up, diff_dn, wrap_dn;
    logic              up_ovf, dn_unf, accept, coarse_chg;
    logic [CodeW-1:0]  calc_code;
    logic              calc_su, calc_sd, calc_sat;
    logic [CntW-1:0]   settle_load;

    always_comb begin
        code_ext = {1'b0, code_q};
        step_ext = {{(CodeW + 1 - STEP_W){1'b0}}, Step};
        sum_up   = code_ext + step_ext;
        diff_dn  = code_ext - step_ext;
        wrap_dn  = code_ext + RangeVal - step_ext;
        up_ovf   = (sum_up >= RangeVal);
        dn_unf   = (step_ext > code_ext);
        accept   = En && (Up ^ Dn) && (Step != '0);
    end

    always_comb begin
        calc_code = code_q;
        calc_su   = 1'b0;
        calc_sd   = 1'b0;
        calc_sat  = 1'b0;
        if (Up) begin
            if (!up_ovf) begin
                calc_code = sum_up[CodeW-1:0];
            end else if (SatEn) begin
                calc_code = '1;
                calc_sat  = 1'b1;
            end else begin
                // sum < 2R, so dropping the top bit subtracts R.
                calc_code = sum_up[CodeW-1:0];
                calc_su   = 1'b1;
            end
        end else begin
            if (!dn_unf) begin
                calc_code = diff_dn[CodeW-1:0];
            end else if (SatEn) begin
                calc_code = '0;
                calc_sat  = 1'b1;
            end else begin
                calc_code = wrap_dn[CodeW-1:0];
                calc_sd   = 1'b1;
            end
        end
    end

    assign coarse_chg  = (pend_q[CodeW-1 -: SEL_W] != code_q[CodeW-1 -: SEL_W]);
    assign settle_load = SettleBase + (coarse_chg ? SettleX : '0);

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        pend_d     = pend_q;
        pslip_up_d = pslip_up_q;
        pslip_dn_d = pslip_dn_q;
        psat_d     = psat_q;
        cnt_d      = cnt_q;
        update_d   = 1'b0;
        slip_up_d  = 1'b0;
        slip_dn_d  = 1'b0;
        sat_d      = 1'b0;
        if (Load) begin
            // Load overrides everything, including a command waiting in APPLY.
            pend_d     = Load_Code;
            pslip_up_d = 1'b0;
            pslip_dn_d = 1'b0;
            psat_d     = 1'b0;
            state_d    = StApply;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        pend_d     = calc_code;
                        pslip_up_d = calc_su;
                        pslip_dn_d = calc_sd;
                        psat_d     = calc_sat;
                        state_d    = StApply;
                    end
                end
                StApply: begin
                    code_d    = pend_q;
                    update_d  = 1'b1;
                    slip_up_d = pslip_up_q;
                    slip_dn_d = pslip_dn_q;
                    sat_d     = psat_q;
                    cnt_d     = settle_load;
                    state_d   = (settle_load == '0) ? StIdle : StSettle;
                end
                StSettle: begin
                    if (cnt_q <= CntW'(1)) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= StIdle;
            code_q     <= '0;
            pend_q     <= '0;
            pslip_up_q <= 1'b0;
            pslip_dn_q <= 1'b0;
            psat_q     <= 1'b0;
            cnt_q      <= '0;
            update_q   <= 1'b0;
            slip_up_q  <= 1'b0;
            slip_dn_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            pend_q     <= pend_d;
            pslip_up_q <= pslip_up_d;
            pslip_dn_q <= pslip_dn_d;
            psat_q     <= psat_d;
            cnt_q      <= cnt_d;
            update_q   <= update_d;
            slip_up_q  <= slip_up_d;
            slip_dn_q  <= slip_dn_d;
            sat_q      <= sat_d;
        end
    end

    assign Code    = code_q;
    assign P1_Sel  = code_q[CodeW-1 -: SEL_W];
    assign P2_Sel  = code_q[CodeW-1 -: SEL_W] + SEL_W'(1);
    assign Update  = update_q;
    assign Busy    = (state_q != StIdle);
    assign Slip_Up = slip_up_q;
    assign Slip_Dn = slip_dn_q;
    assign Sat     = sat_q;

endmodule

// File: tb/tb_pmix_code_ctrl.sv
// Bench for pmix_code_ctrl: wrap (SAT_MODE=0) and clamp (SAT_MODE=1) instances share stimulus;
// every Update is checked against a queue of expected {code, slip_up, slip_dn, sat}.
module tb_pmix_code_ctrl;

    typedef struct packed {
        logic [9:0] code;
        logic       su;
        logic       sd;
        logic       st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up = 1'b0, dn = 1'b0, load = 1'b0;
    logic [3:0] step = '0;
    logic [9:0] load_code = '0;

    logic [9:0] code0, code1;
    logic [1:0] p1_0, p2_0, p1_1, p2_1;
    logic       upd0, busy0, su0, sd0, sat0;
    logic       upd1, busy1, su1, sd1, sat1;

    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   m0 = 0;
    int   m1 = 0;

    always #5 clk = ~clk;

    pmix_code_ctrl #(.SAT_MODE(0)) u_wrap (
        .CLK(clk), .RST_n(rst_n), .En(en), .Up(up), .Dn(dn), .Step(step), .Load(load),
        .Load_Code(load_code), .Code(code0), .P1_Sel(p1_0), .P2_Sel(p2_0), .Update(upd0),
        .Busy(busy0), .Slip_Up(su0), .Slip_Dn(sd0), .Sat(sat0)
    );

    pmix_code_ctrl #(.SAT_MODE(1)) u_sat (
        .CLK(clk), .RST_n(rst_n), .En(en), .Up(up), .Dn(dn), .Step(step), .Load(load),
        .Load_Code(load_code), .Code(code1), .P1_Sel(p1_1), .P2_Sel(p2_1), .Update(upd1),
        .Busy(busy1), .Slip_Up(su1), .Slip_Dn(sd1), .Sat(sat1)
    );

    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst_n && upd0) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL sb_wrap unexpected Update: got code=%h su=%b sd=%b sat=%b",
                         code0, su0, sd0, sat0);
            end else begin
                e = q0.pop_front();
                if ({code0, su0, sd0, sat0} !== e) begin
                    failures++;
                    $display("FAIL sb_wrap got code=%h su=%b sd=%b sat=%b want code=%h su=%b sd=%b sat=%b",
                             code0, su0, sd0, sat0, e.code, e.su, e.sd, e.st);
                end
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && upd1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL sb_sat unexpected Update: got code=%h su=%b sd=%b sat=%b",
                         code1, su1, sd1, sat1);
            end else begin
                e = q1.pop_front();
                if ({code1, su1, sd1, sat1} !== e) begin
                    failures++;
                    $display("FAIL sb_sat got code=%h su=%b sd=%b sat=%b want code=%h su=%b sd=%b sat=%b",
                             code1, su1, sd1, sat1, e.code, e.su, e.sd, e.st);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input int code, input bit is_up, input int stp, input bit sat);
        exp_t e;
        int   n;
        e.su = 1'b0;
        e.sd = 1'b0;
        e.st = 1'b0;
        if (is_up) begin
            n = code + stp;
            if (n >= 1024) begin
                if (sat) begin
                    n = 1023;
                    e.st = 1'b1;
                end else begin
                    n = n - 1024;
                    e.su = 1'b1;
                end
            end
        end else begin
            if (stp > code) begin
                if (sat) begin
                    n = 0;
                    e.st = 1'b1;
                end else begin
                    n = code + 1024 - stp;
                    e.sd = 1'b1;
                end
            end else begin
                n = code - stp;
            end
        end
        e.code = n[9:0];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input bit is_up, input int stp);
        exp_t e0, e1;
        e0 = model(m0, is_up, stp, 1'b0);
        e1 = model(m1, is_up, stp, 1'b1);
        q0.push_back(e0);
        q1.push_back(e1);
        m0 = int'(e0.code);
        m1 = int'(e1.code);
    endtask

    task automatic push_load(input logic [9:0] c);
        exp_t e;
        e.code = c;
        e.su = 1'b0;
        e.sd = 1'b0;
        e.st = 1'b0;
        q0.push_back(e);
        q1.push_back(e);
        m0 = int'(c);
        m1 = int'(c);
    endtask

    task automatic send_cmd(input bit u, input bit d, input logic [3:0] s);
        en = 1'b1;
        up = u;
        dn = d;
        step = s;
        tick();
        en = 1'b0;
        up = 1'b0;
        dn = 1'b0;
        step = '0;
    endtask

    task automatic send_load(input logic [9:0] c);
        load = 1'b1;
        load_code = c;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1) && n < 40) begin
            tick();
            n++;
        end
        if (busy0 || busy1) begin
            checks++;
            failures++;
            $display("FAIL wait_idle still busy after %0d cycles (busy0=%b busy1=%b)", n, busy0, busy1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({code0, p1_0, p2_0} !== {10'h000, 2'd0, 2'd1}) begin
            failures++;
            $display("FAIL reset_code got code=%h p1=%0d p2=%0d want 000/0/1", code0, p1_0, p2_0);
        end
        checks++;
        if ({upd0, busy0, su0, sd0, sat0, upd1, busy1, sat1} !== 8'b0) begin
            failures++;
            $display("FAIL reset_flags got %b want 00000000",
                     {upd0, busy0, su0, sd0, sat0, upd1, busy1, sat1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_step_up();
        push_cmd(1'b1, 1);
        en = 1'b1;
        up = 1'b1;
        step = 4'd1;
        tick();
        en = 1'b0;
        up = 1'b0;
        step = '0;
        checks++;
        if ({busy0, upd0, code0} !== {1'b1, 1'b0, 10'h000}) begin
            failures++;
            $display("FAIL step_up_k got busy=%b upd=%b code=%h want 1/0/000", busy0, upd0, code0);
        end
        tick();
        checks++;
        if ({busy0, upd0, su0, code0} !== {1'b1, 1'b1, 1'b0, 10'h001}) begin
            failures++;
            $display("FAIL step_up_k1 got busy=%b upd=%b su=%b code=%h want 1/1/0/001",
                     busy0, upd0, su0, code0);
        end
        tick();
        checks++;
        if ({busy0, upd0} !== 2'b10) begin
            failures++;
            $display("FAIL step_up_k2 got busy=%b upd=%b want 1/0", busy0, upd0);
        end
        tick();
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL step_up_k3 got busy=%b want 0", busy0);
        end
    endtask

    task automatic test_coarse_cross();
        int n = 0;
        push_load(10'h0FE);
        send_load(10'h0FE);
        wait_idle();
        push_cmd(1'b1, 4);
        send_cmd(1'b1, 1'b0, 4'd4);
        while (busy0 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 7) begin
            failures++;
            $display("FAIL coarse_busy got %0d busy cycles want 7", n);
        end
        checks++;
        if ({code0, p1_0, p2_0} !== {10'h102, 2'd1, 2'd2}) begin
            failures++;
            $display("FAIL coarse_sel got code=%h p1=%0d p2=%0d want 102/1/2", code0, p1_0, p2_0);
        end
        wait_idle();
    endtask

    task automatic test_wrap();
        push_load(10'h3FF);
        send_load(10'h3FF);
        wait_idle();
        push_cmd(1'b1, 1);
        send_cmd(1'b1, 1'b0, 4'd1);
        wait_idle();
        checks++;
        if ({code0, code1} !== {10'h000, 10'h3FF}) begin
            failures++;
            $display("FAIL wrap_up got wrap=%h sat=%h want 000/3FF", code0, code1);
        end
        push_cmd(1'b0, 3);
        send_cmd(1'b0, 1'b1, 4'd3);
        wait_idle();
        checks++;
        if ({code0, code1, p2_0} !== {10'h3FD, 10'h3FC, 2'd0}) begin
            failures++;
            $display("FAIL wrap_dn got wrap=%h sat=%h p2=%0d want 3FD/3FC/0", code0, code1, p2_0);
        end
    endtask

    task automatic test_sat();
        push_load(10'h3FE);
        send_load(10'h3FE);
        wait_idle();
        push_cmd(1'b1, 5);
        send_cmd(1'b1, 1'b0, 4'd5);
        wait_idle();
        checks++;
        if ({code0, code1} !== {10'h003, 10'h3FF}) begin
            failures++;
            $display("FAIL sat_up got wrap=%h sat=%h want 003/3FF", code0, code1);
        end
        push_load(10'h002);
        send_load(10'h002);
        wait_idle();
        push_cmd(1'b0, 5);
        send_cmd(1'b0, 1'b1, 4'd5);
        wait_idle();
        checks++;
        if ({code0, code1} !== {10'h3FD, 10'h000}) begin
            failures++;
            $display("FAIL sat_dn got wrap=%h sat=%h want 3FD/000", code0, code1);
        end
    endtask

    task automatic test_ignored();
        logic [6:0] pats [4];
        logic [6:0] p;
        int         seen;
        pats[0] = {1'b1, 1'b1, 1'b1, 4'd3};
        pats[1] = {1'b1, 1'b1, 1'b0, 4'd0};
        pats[2] = {1'b1, 1'b0, 1'b1, 4'd0};
        pats[3] = {1'b0, 1'b1, 1'b0, 4'd3};
        for (int i = 0; i < 4; i++) begin
            p = pats[i];
            seen = 0;
            en = p[6];
            up = p[5];
            dn = p[4];
            step = p[3:0];
            for (int c = 0; c < 3; c++) begin
                tick();
                if (upd0 || busy0 || upd1 || busy1) seen++;
            end
            en = 1'b0;
            up = 1'b0;
            dn = 1'b0;
            step = '0;
            checks++;
            if (seen !== 0 || int'(code0) !== m0 || int'(code1) !== m1) begin
                failures++;
                $display("FAIL ignored_%0d got activity=%0d code=%h/%h want 0 %h/%h",
                         i, seen, code0, code1, m0[9:0], m1[9:0]);
            end
        end
        // Reloading the current code must still produce an Update.
        push_load(10'h3FD);
        send_load(10'h3FD);
        tick();
        checks++;
        if ({upd0, code0} !== {1'b1, 10'h3FD}) begin
            failures++;
            $display("FAIL reload_same got upd=%b code=%h want 1/3FD", upd0, code0);
        end
        wait_idle();
    endtask

    task automatic test_settle_ignore();
        push_cmd(1'b1, 1);
        en = 1'b1;
        up = 1'b1;
        step = 4'd1;
        tick();
        tick();
        tick();
        en = 1'b0;
        up = 1'b0;
        step = '0;
        checks++;
        if ({busy0, code0} !== {1'b1, 10'h3FE}) begin
            failures++;
            $display("FAIL settle_hold got busy=%b code=%h want 1/3FE", busy0, code0);
        end
        push_load(10'h200);
        send_load(10'h200);
        tick();
        checks++;
        if ({upd0, su0, code0, p1_0} !== {1'b1, 1'b0, 10'h200, 2'd2}) begin
            failures++;
            $display("FAIL settle_load got upd=%b su=%b code=%h p1=%0d want 1/0/200/2",
                     upd0, su0, code0, p1_0);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        push_load(10'h155);
        send_load(10'h155);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        m0 = 0;
        m1 = 0;
        checks++;
        if ({code0, code1, p2_0, busy0, upd0, busy1} !== {10'h000, 10'h000, 2'd1, 3'b000}) begin
            failures++;
            $display("FAIL reset_mid got code=%h/%h p2=%0d busy=%b upd=%b busy1=%b want 000/000/1/0/0/0",
                     code0, code1, p2_0, busy0, upd0, busy1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push_cmd(1'b1, 2);
        send_cmd(1'b1, 1'b0, 4'd2);
        wait_idle();
        checks++;
        if ({code0, code1} !== {10'h002, 10'h002}) begin
            failures++;
            $display("FAIL after_reset got code=%h/%h want 002/002", code0, code1);
        end
    endtask

    initial begin
        test_reset();
        test_step_up();
        test_coarse_cross();
        test_wrap();
        test_sat();
        test_ignored();
        test_settle_ignore();
        test_reset_mid();
        tick();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
